stack_exec: RTL and testbench

STACK_EXEC -- requirements
Module: stack_exec

---
 rtl/stack_exec_if.sv | 24 ++
 rtl/stack_exec.sv | 197 +++++++++++++++++++
 tb/tb_stack_exec.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_exec_if.sv
// Operation-side handshake bundle for stack_exec.
// The master drives requests; the slave (stack_exec) returns completion status and result.
interface stack_exec_if #(
  parameter int WIDTH_DATA = 16
);
  logic                  op_valid;
  logic                  op_ready;
  logic [2:0]            opcode;
  logic [WIDTH_DATA-1:0] imm;
  logic                  done;
  logic                  error;
  logic                  result_valid;
  logic [WIDTH_DATA-1:0] result;

  modport master (
    output op_valid, opcode, imm,
    input  op_ready, done, error, result_valid, result
  );

  modport slave (
    input  op_valid, opcode, imm,
    output op_ready, done, error, result_valid, result
  );
endinterface

// File: rtl/stack_exec.sv
// stack_exec: sequences NOP/PUSH/POP/ADD/SUB/AND/OR/DUP operations onto an
// external stack through single-cycle push/pop strobes.
// Optional feature macro: STACK_EXEC_SAT_EN (ADD/SUB saturate instead of wrapping).
// Stack strobes are decoded from the registered state and the live stack flags,
// because an overflow/underflow decision must use the flags of the strobe cycle.
module stack_exec #(
  parameter int WIDTH_DATA = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  stack_exec_if.slave           op,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [WIDTH_DATA-1:0] stk_data_in,
  input  logic [WIDTH_DATA-1:0] stk_data_out,
  input  logic                  stk_full,
  input  logic                  stk_empty
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_DUP  = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE, S_NOP, S_PUSH, S_POP1, S_POP2,
    S_BIN1, S_BIN2, S_BIN3, S_BIN4, S_BIN5, S_REST,
    S_DUP1, S_DUP2, S_DUP3, S_DUP4, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            opc_q, opc_d;
  logic [WIDTH_DATA-1:0] data_q, data_d;     // pushed word: imm, operand b, or f(a,b)
  logic [WIDTH_DATA-1:0] result_q, result_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  rv_q, rv_d;

  // a is the element below the top, b is the (first-popped) top.
  function automatic logic [WIDTH_DATA-1:0] alu_f(
    input logic [2:0]            opc,
    input logic [WIDTH_DATA-1:0] a,
    input logic [WIDTH_DATA-1:0] b
  );
`ifdef STACK_EXEC_SAT_EN
    logic [WIDTH_DATA:0] sum_s;
    sum_s = {1'b0, a} + {1'b0, b};
`endif
    case (opc)
`ifdef STACK_EXEC_SAT_EN
      OP_ADD:  alu_f = sum_s[WIDTH_DATA] ? {WIDTH_DATA{1'b1}} : sum_s[WIDTH_DATA-1:0];
      OP_SUB:  alu_f = (a < b) ? {WIDTH_DATA{1'b0}} : (a - b);
`else
      OP_ADD:  alu_f = a + b;
      OP_SUB:  alu_f = a - b;
`endif
      OP_AND:  alu_f = a & b;
      OP_OR:   alu_f = a | b;
      default: alu_f = {WIDTH_DATA{1'b0}};
    endcase
  endfunction

  // Next-state, strobe and completion decode for the operation sequencer.
  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    data_d   = data_q;
    result_d = result_q;
    error_d  = 1'b0;
    rv_d     = 1'b0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op.op_valid) begin
          opc_d = op.opcode;
          if (op.opcode == OP_PUSH) begin
            data_d = op.imm;
          end else begin
            data_d = data_q;
          end
          case (op.opcode)
            OP_NOP:  state_d = S_NOP;
            OP_PUSH: state_d = S_PUSH;
            OP_POP:  state_d = S_POP1;
            OP_DUP:  state_d = S_DUP1;
            default: state_d = S_BIN1;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_NOP:  state_d = S_DONE;
      S_PUSH: begin
        if (stk_full) begin
          error_d = 1'b1;
        end else begin
          stk_push = 1'b1;
        end
        state_d = S_DONE;
      end
      S_POP1, S_BIN1, S_DUP1: begin
        if (stk_empty) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          stk_pop = 1'b1;
          state_d = (state_q == S_POP1) ? S_POP2 :
                    (state_q == S_BIN1) ? S_BIN2 : S_DUP2;
        end
      end
      S_POP2: begin
        result_d = stk_data_out;
        rv_d     = 1'b1;
        state_d  = S_DONE;
      end
      S_BIN2: begin
        data_d  = stk_data_out;
        state_d = S_BIN3;
      end
      S_BIN3: begin
        if (stk_empty) begin
          state_d = S_REST;
        end else begin
          stk_pop = 1'b1;
          state_d = S_BIN4;
        end
      end
      S_BIN4: begin
        data_d  = alu_f(opc_q, stk_data_out, data_q);
        state_d = S_BIN5;
      end
      S_BIN5: begin
        stk_push = 1'b1;
        state_d  = S_DONE;
      end
      S_REST: begin
        // b was popped, so a free slot is guaranteed for putting it back
        stk_push = 1'b1;
        error_d  = 1'b1;
        state_d  = S_DONE;
      end
      S_DUP2: begin
        data_d  = stk_data_out;
        state_d = S_DUP3;
      end
      S_DUP3: begin
        stk_push = 1'b1;
        state_d  = S_DUP4;
      end
      S_DUP4: begin
        if (stk_full) begin
          error_d = 1'b1;
        end else begin
          stk_push = 1'b1;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      opc_q    <= 3'b000;
      data_q   <= {WIDTH_DATA{1'b0}};
      result_q <= {WIDTH_DATA{1'b0}};
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      opc_q    <= opc_d;
      data_q   <= data_d;
      result_q <= result_d;
      done_q   <= done_d;
      error_q  <= error_d;
      rv_q     <= rv_d;
    end
  end

  assign op.op_ready     = (state_q == S_IDLE);
  assign op.done         = done_q;
  assign op.error        = error_q;
  assign op.result_valid = rv_q;
  assign op.result       = result_q;
  assign stk_data_in     = data_q;

endmodule

// File: tb/tb_stack_exec.sv
// Table-driven bench for stack_exec with a behavioural 4-deep stack model.
module tb_stack_exec;
  localparam int W     = 16;
  localparam int DEPTH = 4;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_DUP  = 3'b111;

`ifdef STACK_EXEC_SAT_EN
  localparam logic [W-1:0] EXP_SUB_3_9    = 16'h0000;
  localparam logic [W-1:0] EXP_ADD_FFFF_1 = 16'hFFFF;
`else
  localparam logic [W-1:0] EXP_SUB_3_9    = 16'hFFFA;
  localparam logic [W-1:0] EXP_ADD_FFFF_1 = 16'h0000;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  stack_exec_if #(.WIDTH_DATA(W)) op_if ();

  logic         stk_push, stk_pop, stk_full, stk_empty;
  logic [W-1:0] stk_data_in, stk_data_out;

  stack_exec #(.WIDTH_DATA(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .op           (op_if),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .stk_full     (stk_full),
    .stk_empty    (stk_empty)
  );

  // Stack model: pop data and flags appear the cycle after the strobe.
  logic [W-1:0] mem [DEPTH];
  int           sp     = 0;
  logic [W-1:0] dout_q = 16'h0000;
  always @(posedge clk) begin
    if (stk_push && sp < DEPTH) begin
      mem[sp] <= stk_data_in;
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      dout_q <= mem[sp-1];
      sp     <= sp - 1;
    end
  end
  assign stk_data_out = dout_q;
  assign stk_full     = (sp == DEPTH);
  assign stk_empty    = (sp == 0);

  typedef struct {
    logic [2:0]   opc;
    logic [W-1:0] imm;
    int           lat;
    logic         err;
    logic         rv;
    logic [W-1:0] res;
    int           npush;
    int           npop;
    int           depth;
  } vec_t;

  vec_t         vq[$];
  int           n_cmp   = 0;
  int           n_bad   = 0;
  int           cur_idx = 0;
  logic [W-1:0] exp_res = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL [%0d] %s: actual 0x%0h required 0x%0h", cur_idx, name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [2:0] opc, input logic [W-1:0] imm, input int lat,
                         input logic err, input logic rv, input logic [W-1:0] res,
                         input int npush, input int npop, input int depth);
    vec_t v;
    v.opc = opc; v.imm = imm; v.lat = lat; v.err = err; v.rv = rv; v.res = res;
    v.npush = npush; v.npop = npop; v.depth = depth;
    vq.push_back(v);
  endtask

  task automatic wait_ready();
    int waitc;
    waitc = 0;
    @(negedge clk);
    while (!op_if.op_ready && waitc < 20) begin
      @(negedge clk);
      waitc = waitc + 1;
    end
    check("op_ready_before_issue", op_if.op_ready, 1);
  endtask

  task automatic run_op(input vec_t v);
    int lat, pushes, pops;
    wait_ready();
    op_if.op_valid = 1'b1;
    op_if.opcode   = v.opc;
    op_if.imm      = v.imm;
    @(negedge clk);                       // cycle 1
    op_if.op_valid = 1'b0;
    op_if.opcode   = OP_NOP;
    op_if.imm      = 16'hDEAD;            // imm must have been sampled at acceptance
    lat = 1; pushes = 0; pops = 0;
    while (!op_if.done && lat < 20) begin
      check("strobe_exclusive", {31'd0, stk_push & stk_pop}, 0);
      if (stk_push) pushes = pushes + 1;
      if (stk_pop)  pops   = pops + 1;
      @(negedge clk);
      lat = lat + 1;
    end
    if (v.rv) exp_res = v.res;
    check("done_latency", lat, v.lat);
    check("done", op_if.done, 1);
    check("error", op_if.error, v.err);
    check("result_valid", op_if.result_valid, v.rv);
    check("result", op_if.result, exp_res);
    check("op_ready_in_done", op_if.op_ready, 0);
    check("strobes_in_done", {stk_push, stk_pop}, 0);
    check("push_count", pushes, v.npush);
    check("pop_count", pops, v.npop);
    @(negedge clk);
    check("done_pulse_width", op_if.done, 0);
    check("op_ready_after_done", op_if.op_ready, 1);
    check("stack_depth", sp, v.depth);
  endtask

  initial begin
    vec_t v;
    op_if.op_valid = 1'b0;
    op_if.opcode   = OP_NOP;
    op_if.imm      = 16'h0000;

    // opc imm lat err rv res push pop depth
    add_vec(OP_POP,  16'h0000, 2, 1'b1, 1'b0, 16'h0000, 0, 0, 0);
    add_vec(OP_NOP,  16'h0000, 2, 1'b0, 1'b0, 16'h0000, 0, 0, 0);
    add_vec(OP_PUSH, 16'h0005, 2, 1'b0, 1'b0, 16'h0000, 1, 0, 1);
    add_vec(OP_PUSH, 16'h0007, 2, 1'b0, 1'b0, 16'h0000, 1, 0, 2);
    add_vec(OP_ADD,  16'h0000, 6, 1'b0, 1'b0, 16'h0000, 1, 2, 1);
    add_vec(OP_POP,  16'h0000, 3, 1'b0, 1'b1, 16'h000C, 0, 1, 0);
    add_vec(OP_PUSH, 16'h0003, 2, 1'b0, 1'b0, 16'h0000, 1, 0, 1);
    add_vec(OP_PUSH, 16'h0009, 2, 1'b0, 1'b0, 16'h0000, 1, 0, 2);
    add_vec(OP_SUB,  16'h0000, 6, 1'b0, 1'b0, 16'h0000, 1, 2, 1);
    add_vec(OP_POP,  16'h0000, 3, 1'b0, 1'b1, EXP_SUB_3_9, 0, 1, 0);
    add_vec(OP_PUSH, 16'hFFFF, 2, 1'b0, 1'b0, 16'h0000, 1, 0, 1);
    add_vec(OP_PUSH, 16'h0001, 2, 1'b0, 1'b0, 16'h0000, 1, 0, 2);
    add_vec(OP_ADD,  16'h0000, 6, 1'b0, 1'b0, 16'h0000, 1, 2, 1);
    add_vec(OP_POP,  16'h0000, 3, 1'b0, 1'b1, EXP_ADD_FFFF_1, 0, 1, 0);
    add_vec(OP_PUSH, 16'h0009, 2, 1'b0, 1'b0, 16'h0000, 1, 0, 1);
    add_vec(OP_PUSH, 16'h0003, 2, 1'b0, 1'b0, 16'h0000, 1, 0, 2);
    add_vec(OP_SUB,  16'h0000, 6, 1'b0, 1'b0, 16'h0000, 1, 2, 1);
    add_vec(OP_POP,  16'h0000, 3, 1'b0, 1'b1, 16'h0006, 0, 1, 0);
    add_vec(OP_PUSH, 16'h0004, 2, 1'b0, 1'b0, 16'h0000, 1, 0, 1);
    add_vec(OP_ADD,  16'h0000, 5, 1'b1, 1'b0, 16'h0000, 1, 1, 1);
    add_vec(OP_POP,  16'h0000, 3, 1'b0, 1'b1, 16'h0004, 0, 1, 0);
    add_vec(OP_ADD,  16'h0000, 2, 1'b1, 1'b0, 16'h0000, 0, 0, 0);
    add_vec(OP_DUP,  16'h0000, 2, 1'b1, 1'b0, 16'h0000, 0, 0, 0);
    add_vec(OP_PUSH, 16'h00F0, 2, 1'b0, 1'b0, 16'h0000, 1, 0, 1);
    add_vec(OP_PUSH, 16'h0F3C, 2, 1'b0, 1'b0, 16'h0000, 1, 0, 2);
    add_vec(OP_AND,  16'h0000, 6, 1'b0, 1'b0, 16'h0000, 1, 2, 1);
    add_vec(OP_POP,  16'h0000, 3, 1'b0, 1'b1, 16'h0030, 0, 1, 0);
    add_vec(OP_PUSH, 16'h00F0, 2, 1'b0, 1'b0, 16'h0000, 1, 0, 1);
    add_vec(OP_PUSH, 16'h0F0C, 2, 1'b0, 1'b0, 16'h0000, 1, 0, 2);
    add_vec(OP_OR,   16'h0000, 6, 1'b0, 1'b0, 16'h0000, 1, 2, 1);
    add_vec(OP_POP,  16'h0000, 3, 1'b0, 1'b1, 16'h0FFC, 0, 1, 0);
    add_vec(OP_PUSH, 16'h1234, 2, 1'b0, 1'b0, 16'h0000, 1, 0, 1);
    add_vec(OP_DUP,  16'h0000, 5, 1'b0, 1'b0, 16'h0000, 2, 1, 2);
    add_vec(OP_POP,  16'h0000, 3, 1'b0, 1'b1, 16'h1234, 0, 1, 1);
    add_vec(OP_POP,  16'h0000, 3, 1'b0, 1'b1, 16'h1234, 0, 1, 0);
    add_vec(OP_POP,  16'h0000, 2, 1'b1, 1'b0, 16'h0000, 0, 0, 0);
    add_vec(OP_PUSH, 16'h0001, 2, 1'b0, 1'b0, 16'h0000, 1, 0, 1);
    add_vec(OP_PUSH, 16'h0002, 2, 1'b0, 1'b0, 16'h0000, 1, 0, 2);
    add_vec(OP_PUSH, 16'h0003, 2, 1'b0, 1'b0, 16'h0000, 1, 0, 3);
    add_vec(OP_PUSH, 16'h0004, 2, 1'b0, 1'b0, 16'h0000, 1, 0, 4);
    add_vec(OP_PUSH, 16'h0005, 2, 1'b1, 1'b0, 16'h0000, 0, 0, 4);
    add_vec(OP_DUP,  16'h0000, 5, 1'b1, 1'b0, 16'h0000, 1, 1, 4);
    add_vec(OP_POP,  16'h0000, 3, 1'b0, 1'b1, 16'h0004, 0, 1, 3);
    add_vec(OP_POP,  16'h0000, 3, 1'b0, 1'b1, 16'h0003, 0, 1, 2);
    add_vec(OP_POP,  16'h0000, 3, 1'b0, 1'b1, 16'h0002, 0, 1, 1);
    add_vec(OP_POP,  16'h0000, 3, 1'b0, 1'b1, 16'h0001, 0, 1, 0);

    // Reset state
    @(negedge clk);
    #1;
    check("rst_done", op_if.done, 0);
    check("rst_error", op_if.error, 0);
    check("rst_result_valid", op_if.result_valid, 0);
    check("rst_result", op_if.result, 0);
    check("rst_strobes", {stk_push, stk_pop}, 0);
    check("rst_stk_data_in", stk_data_in, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("op_ready_after_release", op_if.op_ready, 1);

    foreach (vq[i]) begin
      cur_idx = i + 1;
      run_op(vq[i]);
    end

    // Reset in cycle 3 of an ADD: the second pop is about to strobe
    cur_idx = 100;
    v.opc = OP_PUSH; v.imm = 16'h0005; v.lat = 2; v.err = 1'b0; v.rv = 1'b0;
    v.res = 16'h0000; v.npush = 1; v.npop = 0; v.depth = 1;
    run_op(v);
    v.imm = 16'h0007; v.depth = 2;
    run_op(v);
    wait_ready();
    op_if.op_valid = 1'b1;
    op_if.opcode   = OP_ADD;
    @(negedge clk);
    op_if.op_valid = 1'b0;
    op_if.opcode   = OP_NOP;
    @(negedge clk);
    @(negedge clk);                       // cycle 3
    check("mid_add_pop_c3", stk_pop, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_strobes", {stk_push, stk_pop}, 0);
    check("mid_rst_done", op_if.done, 0);
    check("mid_rst_error", op_if.error, 0);
    check("mid_rst_result", op_if.result, 0);
    check("mid_rst_stk_data_in", stk_data_in, 0);
    exp_res = 16'h0000;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_op_ready", op_if.op_ready, 1);
    check("mid_rst_depth", sp, 1);
    v.imm = 16'h0008; v.depth = 2;
    run_op(v);
    v.opc = OP_POP; v.lat = 3; v.rv = 1'b1; v.res = 16'h0008; v.npush = 0; v.npop = 1; v.depth = 1;
    run_op(v);
    v.res = 16'h0005; v.depth = 0;
    run_op(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
